// File: rtl/uart_pkg.sv
// Shared UART definitions: framing width and the launch FSM state encoding.
package uart_pkg;

  localparam int unsigned BITS_PER_FRAME = 8;

  typedef enum logic [1:0] {
    QIdle,
    QLaunch,
    QWaitBusy,
    QWaitDone
  } q_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with push/pop/flush; occupancy tracked by an explicit counter.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [BITS_PER_FRAME-1:0] push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [BITS_PER_FRAME-1:0] head_data,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH_LOG2:0]       count,
  output logic                      overflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [BITS_PER_FRAME-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]     head_q, head_d;
  logic [DEPTH_LOG2-1:0]     tail_q, tail_d;
  logic [DEPTH_LOG2:0]       count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic                      push_ok, pop_ok;

  // Flush dominates both push and pop; a push against a full queue is dropped.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  // Next-state for pointers, occupancy and the overflow pulse.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = push & full & ~flush;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign overflow  = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue: buffers bytes and launches them one per UART busy period.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [BITS_PER_FRAME-1:0] wr_data,
  input  logic                      flush,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH_LOG2:0]       count,
  output logic                      overflow,
  output logic                      uart_transmit,
  output logic [BITS_PER_FRAME-1:0] uart_tx_byte,
  input  logic                      uart_busy
);

  q_state_e                  state_q, state_d;
  logic [BITS_PER_FRAME-1:0] tx_byte_q;
  logic [BITS_PER_FRAME-1:0] head_data;
  logic                      launch;

  // Leaving idle pops the head on the same edge; a concurrent flush cancels it.
  assign launch = (state_q == QIdle) & ~empty & ~uart_busy & ~flush;

  uart_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (launch),
    .flush     (flush),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= QIdle;
    else      state_q <= state_d;
  end

  // Next-state: wait for busy to rise and then fall before the next launch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      QIdle:     if (launch) state_d = QLaunch;
      QLaunch:   state_d = QWaitBusy;
      QWaitBusy: if (uart_busy) state_d = QWaitDone;
      QWaitDone: if (!uart_busy) state_d = QIdle;
      default:   state_d = QIdle;
    endcase
  end

  // Launched byte is held until the next launch.
  always_ff @(posedge clk) begin
    if (!rst)        tx_byte_q <= '0;
    else if (launch) tx_byte_q <= head_data;
  end

  // Outputs.
  always_comb begin
    uart_transmit = (state_q == QLaunch);
    uart_tx_byte  = tx_byte_q;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a simple UART busy model.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       full, empty, overflow, uart_transmit;
  logic [4:0] count;
  logic [7:0] uart_tx_byte;
  logic       uart_busy;

  logic busy_force = 1'b0;
  logic busy_model = 1'b0;
  logic model_en   = 1'b0;
  int   frame_len  = 20;
  int   busy_cnt   = 0;
  int   viol       = 0;
  int   n_checks   = 0;
  int   n_pass     = 0;
  logic [7:0] log_q[$];

  assign uart_busy = busy_force | busy_model;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DEPTH_LOG2 (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .flush         (flush),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .uart_transmit (uart_transmit),
    .uart_tx_byte  (uart_tx_byte),
    .uart_busy     (uart_busy)
  );

  // UART model: busy rises the cycle after a launch and stays high frame_len cycles.
  always @(posedge clk) begin
    if (!model_en) begin
      busy_model <= 1'b0;
      busy_cnt   <= 0;
    end else if (busy_model) begin
      if (busy_cnt == 0) busy_model <= 1'b0;
      else               busy_cnt   <= busy_cnt - 1;
    end else if (uart_transmit === 1'b1) begin
      busy_model <= 1'b1;
      busy_cnt   <= frame_len - 1;
    end
  end

  // Launch log; a launch seen while the line is busy is a protocol violation.
  always @(posedge clk) begin
    if (uart_transmit === 1'b1) begin
      log_q.push_back(uart_tx_byte);
      if (uart_busy) viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int i;
    i = 0;
    while (log_q.size() < n && i < budget) begin
      step();
      i++;
    end
    check("wait_budget", i < budget, 1);
  endtask

  initial begin
    // Reset hold with a push attempted every cycle.
    rst = 1'b0; wr_en = 1'b1; wr_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_tx", uart_transmit, 0);
      check("rst_byte", uart_tx_byte, 8'h00);
    end
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    wr_en = 1'b0; rst = 1'b1; model_en = 1'b1; frame_len = 28;
    step(); step();

    // Single byte: transmit two cycles after the push, busy for 28 cycles.
    log_q.delete();
    wr_en = 1'b1; wr_data = 8'hA5; step(); wr_en = 1'b0;
    check("sb_count1", count, 1);
    check("sb_tx_early", uart_transmit, 0);
    step();
    check("sb_tx", uart_transmit, 1);
    check("sb_byte", uart_tx_byte, 8'hA5);
    check("sb_empty", empty, 1);
    step();
    check("sb_busy", uart_busy, 1);
    check("sb_tx_once", uart_transmit, 0);
    repeat (35) step();
    check("sb_launches", log_q.size(), 1);
    check("sb_hold", uart_tx_byte, 8'hA5);
    check("sb_busy_low", uart_busy, 0);

    // Burst of five bytes against 20-cycle frames.
    log_q.delete(); frame_len = 20;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); step();
    end
    wr_en = 1'b0;
    wait_log(5, 400);
    repeat (30) step();
    check("burst_n", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("burst_order", log_q[i], 32'(i + 1));

    // Fill to full, overflow once, drain in order; three rounds to wrap pointers.
    frame_len = 3;
    for (int r = 0; r < 3; r++) begin
      log_q.delete(); busy_force = 1'b1;
      for (int i = 0; i < 16; i++) begin
        wr_en = 1'b1; wr_data = 8'(r * 16 + i + 16); step();
      end
      check("fill_full", full, 1);
      check("fill_count", count, 16);
      check("fill_no_ovf", overflow, 0);
      wr_data = 8'hEE; step(); wr_en = 1'b0;
      check("ovf_pulse", overflow, 1);
      check("ovf_count", count, 16);
      step();
      check("ovf_clear", overflow, 0);
      busy_force = 1'b0;
      wait_log(16, 600);
      repeat (10) step();
      check("drain_n", log_q.size(), 16);
      for (int i = 0; i < 16; i++) check("drain_order", log_q[i], 32'(r * 16 + i + 16));
      check("drain_empty", empty, 1);
    end

    // Flush while a frame is in flight with six bytes queued.
    log_q.delete(); frame_len = 30;
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i); step();
    end
    check("fl_pre_count", count, 6);
    check("fl_pre_busy", uart_busy, 1);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; step();
    flush = 1'b0; wr_en = 1'b0;
    check("fl_count", count, 0);
    check("fl_empty", empty, 1);
    repeat (60) step();
    check("fl_launches", log_q.size(), 1);
    check("fl_first", log_q[0], 8'h60);
    check("fl_busy_done", uart_busy, 0);

    // Reset on the edge that would enter the launch state.
    log_q.delete();
    wr_en = 1'b1; wr_data = 8'h3C; step(); wr_en = 1'b0;
    check("mr_count1", count, 1);
    rst = 1'b0; step(); rst = 1'b1;
    check("mr_tx", uart_transmit, 0);
    check("mr_count", count, 0);
    check("mr_empty", empty, 1);
    check("mr_full", full, 0);
    check("mr_ovf", overflow, 0);
    check("mr_byte", uart_tx_byte, 8'h00);
    step(); step();
    check("mr_no_launch", log_q.size(), 0);
    check("mr_tx_after", uart_transmit, 0);

    check("busy_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
